// File: rtl/regfile_read_stage_pkg.sv
// Shared constants and the ID/EX payload type for the register-read stage.
package regfile_read_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 7;

    typedef struct packed {
        logic                  valid;
        logic [INSTR_W-1:0]    instr;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] rs1_data;
        logic [REG_DATA_W-1:0] rs2_data;
        logic                  mem_read;
    } id_ex_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: one negedge write port, two combinational read ports, x0 hardwired to 0.
module regfile_2r1w #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [N-1:0]      rdata1,
    output logic [N-1:0]      rdata2
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [N-1:0] mem [Depth];

    // Negedge write lets an instruction in ID see a same-cycle write-back without a bypass.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
    end

endmodule

// File: rtl/regfile_read_stage.sv
// Stage-2 register read: field decode, load-use hazard detection and the ID/EX pipeline register.
module regfile_read_stage
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [N-1:0]      wb_data,
    output logic              hazard_stall,
    output logic              id_ex_valid,
    output logic [31:0]       id_ex_instr,
    output logic [ADDR_W-1:0] id_ex_rs1,
    output logic [ADDR_W-1:0] id_ex_rs2,
    output logic [ADDR_W-1:0] id_ex_rd,
    output logic [N-1:0]      id_ex_rs1_data,
    output logic [N-1:0]      id_ex_rs2_data,
    output logic              id_ex_mem_read
);

    logic [ADDR_W-1:0] rs1, rs2, rd;
    logic [OPC_W-1:0]  opcode;
    logic [N-1:0]      rs1_data, rs2_data;
    id_ex_t            id_ex_d, id_ex_q;

    assign rs1    = instr[RS1_LSB +: ADDR_W];
    assign rs2    = instr[RS2_LSB +: ADDR_W];
    assign rd     = instr[RD_LSB +: ADDR_W];
    assign opcode = instr[OPC_LSB +: OPC_W];

    regfile_2r1w #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        hazard_stall = rst_n & instr_valid & id_ex_q.valid & id_ex_q.mem_read &
                       (id_ex_q.rd != '0) & ((id_ex_q.rd == rs1) | (id_ex_q.rd == rs2));
    end

    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d = '0;
        end else if (stall) begin
            id_ex_d = id_ex_q;
        end else if (hazard_stall) begin
            id_ex_d = '0;
        end else begin
            id_ex_d.valid    = instr_valid;
            id_ex_d.instr    = instr;
            id_ex_d.rs1      = rs1;
            id_ex_d.rs2      = rs2;
            id_ex_d.rd       = rd;
            id_ex_d.rs1_data = rs1_data;
            id_ex_d.rs2_data = rs2_data;
            id_ex_d.mem_read = (opcode == OPC_LOAD) & instr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_valid    = id_ex_q.valid;
    assign id_ex_instr    = id_ex_q.instr;
    assign id_ex_rs1      = id_ex_q.rs1;
    assign id_ex_rs2      = id_ex_q.rs2;
    assign id_ex_rd       = id_ex_q.rd;
    assign id_ex_rs1_data = id_ex_q.rs1_data;
    assign id_ex_rs2_data = id_ex_q.rs2_data;
    assign id_ex_mem_read = id_ex_q.mem_read;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed self-checking bench for regfile_read_stage.
module tb_regfile_read_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid, stall, flush, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard_stall, id_ex_valid, id_ex_mem_read;
    logic [31:0] id_ex_instr, id_ex_rs1_data, id_ex_rs2_data;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_read_stage #(
        .N      (32),
        .ADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .hazard_stall   (hazard_stall),
        .id_ex_valid    (id_ex_valid),
        .id_ex_instr    (id_ex_instr),
        .id_ex_rs1      (id_ex_rs1),
        .id_ex_rs2      (id_ex_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_rs1_data (id_ex_rs1_data),
        .id_ex_rs2_data (id_ex_rs2_data),
        .id_ex_mem_read (id_ex_mem_read)
    );

    // add rd, rs1, rs2 (R-type, opcode 0110011)
    function automatic logic [31:0] add_op(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hFFFF_FFFF;
        instr = 32'h0000_A383; instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        step();
        step();
        checks++; if (id_ex_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %h exp 0", id_ex_valid); end
        checks++; if (id_ex_instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr got %h exp 0", id_ex_instr); end
        checks++; if ({id_ex_rs1, id_ex_rs2, id_ex_rd} !== 15'h0) begin errors++;
            $display("FAIL reset_fields got %h exp 0", {id_ex_rs1, id_ex_rs2, id_ex_rd}); end
        checks++; if ({id_ex_rs1_data, id_ex_rs2_data} !== 64'h0) begin errors++;
            $display("FAIL reset_data got %h exp 0", {id_ex_rs1_data, id_ex_rs2_data}); end
        checks++; if (id_ex_mem_read !== 1'b0) begin errors++;
            $display("FAIL reset_mem_read got %h exp 0", id_ex_mem_read); end
        checks++; if (hazard_stall !== 1'b0) begin errors++;
            $display("FAIL reset_hazard got %h exp 0", hazard_stall); end
        rst_n = 1'b1; wb_en = 1'b0;
        for (int r = 1; r < 32; r++) begin
            instr = add_op(5'd1, 5'(r), 5'(r));
            step();
            checks++; if ({id_ex_rs1_data, id_ex_rs2_data} !== 64'h0) begin errors++;
                $display("FAIL reset_read_x%0d got %h exp 0", r, id_ex_rs1_data); end
        end
    endtask

    task automatic test_same_cycle_wr();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        instr = 32'h0002_81B3; instr_valid = 1'b1;  // add x3, x5, x0
        step();
        wb_en = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL same_cycle_rs1_data got %h exp deadbeef", id_ex_rs1_data); end
        checks++; if (id_ex_rs2_data !== 32'h0) begin errors++;
            $display("FAIL same_cycle_rs2_data got %h exp 0", id_ex_rs2_data); end
        checks++; if (id_ex_rd !== 5'd3) begin errors++;
            $display("FAIL same_cycle_rd got %0d exp 3", id_ex_rd); end
        checks++; if (id_ex_rs1 !== 5'd5) begin errors++;
            $display("FAIL same_cycle_rs1 got %0d exp 5", id_ex_rs1); end
        checks++; if (id_ex_instr !== 32'h0002_81B3) begin errors++;
            $display("FAIL same_cycle_instr got %h exp 000281b3", id_ex_instr); end
        checks++; if ({id_ex_valid, id_ex_mem_read} !== 2'b10) begin errors++;
            $display("FAIL same_cycle_valid_mr got %b exp 10", {id_ex_valid, id_ex_mem_read}); end
    endtask

    task automatic test_x0_write();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        instr = add_op(5'd1, 5'd0, 5'd0);
        step();
        wb_en = 1'b0;
        step();
        checks++; if (id_ex_rs1_data !== 32'h0) begin errors++;
            $display("FAIL x0_write got %h exp 0", id_ex_rs1_data); end
    endtask

    task automatic test_load_use();
        instr = 32'h0000_A383;  // lw x7, 0(x1)
        step();
        checks++; if ({id_ex_mem_read, id_ex_rd} !== {1'b1, 5'd7}) begin errors++;
            $display("FAIL lu_load got mr=%b rd=%0d exp mr=1 rd=7", id_ex_mem_read, id_ex_rd); end
        instr = 32'h0023_8433;  // add x8, x7, x2
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++;
            $display("FAIL lu_hazard got %b exp 1", hazard_stall); end
        step();
        checks++; if (id_ex_valid !== 1'b0) begin errors++;
            $display("FAIL lu_bubble got %b exp 0", id_ex_valid); end
        checks++; if (hazard_stall !== 1'b0) begin errors++;
            $display("FAIL lu_hazard_clear got %b exp 0", hazard_stall); end
        step();
        checks++; if ({id_ex_valid, id_ex_rs1, id_ex_rd} !== {1'b1, 5'd7, 5'd8}) begin errors++;
            $display("FAIL lu_issue got v=%b rs1=%0d rd=%0d exp v=1 rs1=7 rd=8",
                     id_ex_valid, id_ex_rs1, id_ex_rd); end
        instr = 32'h0000_A003;  // lw x0, 0(x1)
        step();
        instr = 32'h0020_0433;  // add x8, x0, x2
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++;
            $display("FAIL lu_rd0_hazard got %b exp 0", hazard_stall); end
        step();
        checks++; if ({id_ex_valid, id_ex_rd} !== {1'b1, 5'd8}) begin errors++;
            $display("FAIL lu_rd0_issue got v=%b rd=%0d exp v=1 rd=8", id_ex_valid, id_ex_rd); end
    endtask

    task automatic test_wb_during_hazard();
        instr = 32'h0000_A383;  // lw x7, 0(x1)
        step();
        instr = 32'h0023_8433;  // add x8, x7, x2
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h99;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++;
            $display("FAIL wbh_hazard got %b exp 1", hazard_stall); end
        step();
        wb_en = 1'b0;
        checks++; if (id_ex_valid !== 1'b0) begin errors++;
            $display("FAIL wbh_bubble got %b exp 0", id_ex_valid); end
        step();
        checks++; if (id_ex_rs1_data !== 32'h99) begin errors++;
            $display("FAIL wbh_data got %h exp 99", id_ex_rs1_data); end
    endtask

    task automatic test_stall_flush();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        instr = 32'h0002_00B3;  // add x1, x4, x0
        step();
        checks++; if (id_ex_rs1_data !== 32'h55) begin errors++;
            $display("FAIL sf_capture got %h exp 55", id_ex_rs1_data); end
        stall = 1'b1; wb_data = 32'hAA;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({id_ex_valid, id_ex_rs1_data} !== {1'b1, 32'h55}) begin errors++;
                $display("FAIL sf_hold%0d got v=%b d=%h exp v=1 d=55",
                         c, id_ex_valid, id_ex_rs1_data); end
        end
        wb_en = 1'b0; flush = 1'b1;
        step();
        checks++; if (id_ex_valid !== 1'b0) begin errors++;
            $display("FAIL sf_flush got %b exp 0", id_ex_valid); end
        stall = 1'b0; flush = 1'b0;
        step();
        checks++; if (id_ex_rs1_data !== 32'hAA) begin errors++;
            $display("FAIL sf_after got %h exp aa", id_ex_rs1_data); end
    endtask

    task automatic test_reset_mid();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
        instr = 32'h0004_80B3;  // add x1, x9, x0
        step();
        wb_en = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'h77) begin errors++;
            $display("FAIL rm_before got %h exp 77", id_ex_rs1_data); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; instr_valid = 1'b0;
        checks++; if (id_ex_valid !== 1'b0) begin errors++;
            $display("FAIL rm_valid got %b exp 0", id_ex_valid); end
        instr_valid = 1'b1;
        step();
        checks++; if ({id_ex_valid, id_ex_rs1_data} !== {1'b1, 32'h0}) begin errors++;
            $display("FAIL rm_read_x9 got v=%b d=%h exp v=1 d=0", id_ex_valid, id_ex_rs1_data); end
    endtask

    initial begin
        test_reset();
        test_same_cycle_wr();
        test_x0_write();
        test_load_use();
        test_wb_during_hazard();
        test_stall_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
# regfile_read_stage

Stage-2 register-read block: decodes register fields from the IF/ID instruction, reads two operands from a 32-entry integer register file, and launches them into the ID/EX pipeline register. Accepts the write-back port from the last stage and detects load-use hazards against the instruction currently in ID/EX. The register file is written on the falling clock edge; ID/EX is captured on the rising edge.

## Interface
- N, 32, data width of each register
- ADDR_W, 5, register address width (2**ADDR_W entries)

- clk  in  1  clock; register file on negedge, ID/EX register on posedge
- rst_n  in  1  reset, synchronous, active-low
- instr  in  32  instruction from IF/ID
- instr_valid  in  1  instr holds a real instruction
- stall  in  1  hold ID/EX contents
- flush  in  1  replace ID/EX with a bubble
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  N  write-back data
- hazard_stall  out  1  combinational; upstream must hold IF/ID
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_instr  out  32  instruction word
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  ADDR_W  register fields
- id_ex_rs1_data, id_ex_rs2_data  out  N  operand values
- id_ex_mem_read  out  1  instruction is a load (opcode 7'b0000011)

## Operation
- Fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
- Register file, negedge: rst_n=0 → all entries 0; else wb_en=1 and wb_addr≠0 → entry[wb_addr]<=wb_data. Writes to x0 are dropped.
- Reads are combinational; address 0 always returns 0.
- hazard_stall = instr_valid & id_ex_valid & id_ex_mem_read & (id_ex_rd≠0) & (id_ex_rd==rs1 | id_ex_rd==rs2). It is forced to 0 while rst_n=0.
- ID/EX update, posedge, priority order:
  - rst_n=0 → all id_ex_* outputs 0.
  - flush=1 → bubble: all id_ex_* outputs 0. Flush overrides stall.
  - stall=1 → hold all outputs unchanged. Held operands are not refreshed by later write-backs; EX forwarding covers that case.
  - hazard_stall=1 → bubble.
  - else → capture fields and read data; id_ex_valid<=instr_valid; id_ex_mem_read<=(opcode==LOAD) & instr_valid.
- No unknown-opcode checking; illegal instructions pass through.

## Timing
- Reset value of every output is 0; hazard_stall is 0 during reset.
- Write-before-read: a write-back presented in cycle k is stored on the negedge inside cycle k. An instruction reading the same register in cycle k captures the new value at the end of cycle k. No read bypass mux.
- Latency: instr to id_ex_* is 1 posedge.
- Load-use penalty: exactly 1 bubble. The dependent instruction issues on the cycle after the bubble, when ID/EX no longer holds the load.
- Reset is sampled at both edges. Asserting rst_n mid-operation clears the register file at the next negedge and ID/EX at the next posedge; any write-back in that cycle is lost.
- Simultaneous wb_en to register r and hazard on r: the write still occurs, and the bubble is still inserted.

## Structure
- Shared package: OPC_LOAD=7'b0000011, ADDR_W, field bit-position constants, and a struct/bundle for the ID/EX payload.
- Sub-module regfile_2r1w (params N, ADDR_W) contains:
  - the negedge array with synchronous active-low clear;
  - two combinational read ports with the x0=0 rule.
- Top level contains field decode, the hazard comparator and the posedge ID/EX register.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with wb_en=1 → all id_ex_* outputs and hazard_stall are 0, and reading x1..x31 afterwards gives 0.
- Same-cycle write/read: wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF, with instr add x3,x5,x0 valid in the same cycle → next posedge gives id_ex_rs1_data=32'hDEADBEEF, id_ex_rs2_data=0, id_ex_rd=3.
- x0 write: wb_addr=0, wb_data=32'h1234, then an instr reading rs1=x0 → id_ex_rs1_data=0.
- Load-use: lw x7 captured (id_ex_mem_read=1, id_ex_rd=7), then add x8,x7,x2 presented:
  - hazard_stall=1 in that cycle;
  - next id_ex_valid=0;
  - following cycle id_ex_rs1=7, id_ex_valid=1.
  - Repeat with rd=0 → no hazard.
- Stall/flush:
  - capture x4=32'h55, then stall=1 for 3 cycles while writing x4=32'hAA → outputs hold 32'h55;
  - stall=1 and flush=1 together → id_ex_valid=0.
- Reset mid-stream: write x9=32'h77, then pulse rst_n=0 for 1 cycle, then read x9 → 0, and id_ex_valid=0 after the reset cycle.
